addr_bus_responder: RTL and testbench
=====================================

# addr_bus_responder

Target-side responder for the 6-bit addr / wr / en stimulus bus driven by the team's bus stimulus tasks on the 25 MHz clock. Holds a DEPTH x 8 register array and completes writes in a single cycle. Answers reads through a counted wait-state FSM, flags out-of-range accesses, and optionally keeps access statistics. Sits directly on the bus as the device under test for stimulus-generation benches.

## Interface
- DEPTH, 48, number of implemented byte locations; valid addresses 0..DEPTH-1; legal range 1..64
- WAIT_CYCLES, 1, read wait states inserted before rvalid; legal range 0..15
- clk  input  1  bus clock (25 MHz nominal); all sampling on rising edge
- rst  input  1  reset; asynchronous, active-high
- en  input  1  access request, sampled on posedge clk
- wr  input  1  1 = write, 0 = read; qualified by en
- addr  input  6  byte address
- wdata  input  8  write data, sampled with en&wr
- ready  output  1  responder can accept a request this cycle
- rdata  output  8  read data, valid only while rvalid=1
- rvalid  output  1  one-cycle read-complete strobe
- err  output  1  one-cycle strobe for a rejected out-of-range access
- wr_count  output  16  accepted-write counter
- rd_count  output  16  completed-read counter

## Operation
- FSM states: IDLE, WAIT, RESP, ERR.
- A request is accepted on a rising edge where en=1 and ready=1. ready=1 only in IDLE.
- en sampled while ready=0 is ignored: no state change, no error, not queued.
- IDLE, accepted, addr>=DEPTH, either wr value → ERR. No array update.
- IDLE, accepted write, addr<DEPTH → mem[addr]<=wdata on that edge; stay IDLE; ready stays 1. Back-to-back writes are allowed every cycle.
- IDLE, accepted read, addr<DEPTH:
  - Capture addr.
  - WAIT_CYCLES>0 → WAIT, cnt<=WAIT_CYCLES-1.
  - WAIT_CYCLES=0 → RESP.
- WAIT: cnt==0 → RESP; else cnt<=cnt-1.
- RESP: rvalid=1, rdata=mem[captured addr]; → IDLE next edge.
- ERR: err=1; → IDLE next edge.
- rdata holds its last value outside RESP; it is 0 after reset.
- Read-after-write to the same address in the following cycle returns the new data.
- Reset values:
  - state IDLE
  - ready=1, rvalid=0, err=0
  - rdata=0x00
  - all mem locations 0x00
  - cnt=0
  - wr_count=0, rd_count=0
- Reset asserted mid-read clears immediately and asynchronously. The pending read is discarded and no rvalid is produced.

## Timing
- Write: data visible in the array after the accepting edge N.
- Read accepted at edge N:
  - RESP entered at edge N+WAIT_CYCLES.
  - rvalid high for exactly one cycle, between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1.
  - ready returns to 1 after edge N+WAIT_CYCLES+1.
  - Earliest next accept is edge N+WAIT_CYCLES+2 when WAIT_CYCLES>0, or N+2 when WAIT_CYCLES=0.
- Error accepted at edge N: err high between edges N and N+1; next accept at edge N+2.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ACCESS_STATS_EN defined:
  - wr_count increments on each accepted in-range write.
  - rd_count increments on entry to RESP.
  - Both wrap 0xFFFF→0x0000.
  - Error accesses are counted by neither.
- ACCESS_STATS_EN undefined: counter logic is absent and wr_count/rd_count are tied to 0.

## Test plan
- Reset, then write 0xA5 to addr 12 and 0x3C to addr 14 on consecutive edges → ready stays 1; reads of 12 and 14 return rvalid with rdata 0xA5 and 0x3C.
- WAIT_CYCLES=1, read addr 23 (reset contents) accepted at edge N → rvalid=1, rdata=0x00 between edges N+1 and N+2; ready=0 from N to N+2.
- DEPTH=48: write to addr 48, then read addr 56 → err pulses one cycle each; mem unchanged; no rvalid; counters unchanged.
- en=1 held through a read's WAIT/RESP cycles with a different addr → those requests are ignored; exactly one rvalid occurs.
- rst asserted between edges N and N+1 of a pending read to addr 23 → rvalid never rises; ready=1 and memory reads back 0x00 after release.
- ACCESS_STATS_EN defined: 3 writes and 2 reads → wr_count=3, rd_count=2. Undefined: both remain 0.

Source files
------------

// File: rtl/addr_bus_responder.sv
// Bus responder with a DEPTH x 8 register array, single-cycle writes and wait-stated reads.
// Define ACCESS_STATS_EN to build the write/read access counters; otherwise they read as 0.
module addr_bus_responder #(
    parameter int DEPTH       = 48,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr,
    input  logic [5:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        err,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [6:0] DEPTH_L  = 7'(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] addr_q, addr_d;
    logic       ready_q, rvalid_q, err_q;
    logic [7:0] rdata_q;
    logic [7:0] rd_byte;
    logic [7:0] mem_q [DEPTH];

    logic accept, in_range, wr_en;

    assign accept   = en & ready_q;
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign wr_en    = accept & wr & in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        state_d = S_ERR;
                    end else if (!wr) begin
                        addr_d = addr;
                        if (WAIT_CYCLES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = S_RESP;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // addr_d already carries the live address for a zero-wait read, so one mux serves both paths.
    always_comb begin
        rd_byte = 8'h00;
        if ({1'b0, addr_d} < DEPTH_L) rd_byte = mem_q[addr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 6'd0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            ready_q  <= (state_d == S_IDLE);
            rvalid_q <= (state_d == S_RESP);
            err_q    <= (state_d == S_ERR);
            if (state_d == S_RESP) rdata_q <= rd_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (wr_en) begin
            mem_q[addr] <= wdata;
        end
    end

`ifdef ACCESS_STATS_EN
    logic [15:0] wr_count_q, rd_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            if (wr_en)              wr_count_q <= wr_count_q + 16'd1;
            if (state_d == S_RESP)  rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`else
    assign wr_count = 16'd0;
    assign rd_count = 16'd0;
`endif

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_addr_bus_responder.sv
// Directed bench for addr_bus_responder at DEPTH=48, WAIT_CYCLES=1 (25 MHz clock).
module tb_addr_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, wr;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic        ready, rvalid, err;
    logic [7:0]  rdata;
    logic [15:0] wr_count, rd_count;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt   = 0;
    int rv_mark;

    always #20 clk = ~clk;

    addr_bus_responder #(.DEPTH(48), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always @(posedge clk) if (rvalid === 1'b1) rv_cnt++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read with one wait state: accept at N, rvalid between N+1 and N+2.
    task automatic do_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
        en = 1'b1; wr = 1'b0; addr = a;
        step();
        en = 1'b0;
        check({tag, "_ready_n"}, 16'(ready), 16'd0);
        check({tag, "_rvalid_n"}, 16'(rvalid), 16'd0);
        step();
        check({tag, "_rvalid_n1"}, 16'(rvalid), 16'd1);
        check({tag, "_rdata"}, 16'(rdata), 16'(exp));
        check({tag, "_ready_n1"}, 16'(ready), 16'd0);
        step();
        check({tag, "_rvalid_n2"}, 16'(rvalid), 16'd0);
        check({tag, "_ready_n2"}, 16'(ready), 16'd1);
        $display("read  addr=%0d rdata=%h", a, exp);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        step();
        en = 1'b0;
        check("wr_ready", 16'(ready), 16'd1);
        $display("write addr=%0d wdata=%h", a, d);
    endtask

    task automatic do_err(input string tag, input logic w, input logic [5:0] a);
        en = 1'b1; wr = w; addr = a; wdata = 8'hFF;
        step();
        en = 1'b0;
        check({tag, "_err_n"}, 16'(err), 16'd1);
        check({tag, "_ready_n"}, 16'(ready), 16'd0);
        check({tag, "_rvalid_n"}, 16'(rvalid), 16'd0);
        step();
        check({tag, "_err_n1"}, 16'(err), 16'd0);
        check({tag, "_ready_n1"}, 16'(ready), 16'd1);
        $display("error wr=%0d addr=%0d", w, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_wr, exp_rd;
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = 6'd0; wdata = 8'h00;
        step(); step();
        check("rst_ready", 16'(ready), 16'd1);
        check("rst_rvalid", 16'(rvalid), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_rdata", 16'(rdata), 16'h00);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst_rd_count", rd_count, 16'd0);
        rst = 1'b0;
        step();

        // Back-to-back writes, then read back.
        en = 1'b1; wr = 1'b1; addr = 6'd12; wdata = 8'hA5;
        step();
        check("b2b_ready0", 16'(ready), 16'd1);
        $display("write addr=12 wdata=a5");
        addr = 6'd14; wdata = 8'h3C;
        step();
        check("b2b_ready1", 16'(ready), 16'd1);
        $display("write addr=14 wdata=3c");
        en = 1'b0;
        do_read("rd12", 6'd12, 8'hA5);
        do_read("rd14", 6'd14, 8'h3C);

        // Read-after-write on the very next edge.
        en = 1'b1; wr = 1'b1; addr = 6'd5; wdata = 8'h77;
        step();
        $display("write addr=5 wdata=77");
        do_read("raw5", 6'd5, 8'h77);

        do_read("rd23", 6'd23, 8'h00);

        // Out-of-range accesses.
        rv_mark = rv_cnt;
        do_err("err_wr48", 1'b1, 6'd48);
        do_err("err_rd56", 1'b0, 6'd56);
        check("err_no_rvalid", 16'(rv_cnt - rv_mark), 16'd0);
`ifdef ACCESS_STATS_EN
        exp_wr = 16'd3; exp_rd = 16'd4;
`else
        exp_wr = 16'd0; exp_rd = 16'd0;
`endif
        check("err_wr_count", wr_count, exp_wr);
        check("err_rd_count", rd_count, exp_rd);
        do_read("alias0", 6'd0, 8'h00);
        do_read("alias16", 6'd16, 8'h00);
        do_read("alias47", 6'd47, 8'h00);

        // en held through WAIT/RESP with a different address.
        rv_mark = rv_cnt;
        en = 1'b1; wr = 1'b0; addr = 6'd12;
        step();
        addr = 6'd14;
        check("hold_ready_n", 16'(ready), 16'd0);
        step();
        check("hold_rvalid", 16'(rvalid), 16'd1);
        check("hold_rdata", 16'(rdata), 16'h00A5);
        step();
        en = 1'b0;
        check("hold_rvalid_off", 16'(rvalid), 16'd0);
        step(); step();
        check("hold_one_rvalid", 16'(rv_cnt - rv_mark), 16'd1);
        $display("read  addr=12 with en held, rdata=a5");

        // Asynchronous reset during a pending read.
        rv_mark = rv_cnt;
        en = 1'b1; wr = 1'b0; addr = 6'd23;
        step();
        en = 1'b0;
        #5 rst = 1'b1;
        #5;
        check("arst_ready", 16'(ready), 16'd1);
        check("arst_rvalid", 16'(rvalid), 16'd0);
        step();
        rst = 1'b0;
        step(); step(); step();
        check("arst_no_rvalid", 16'(rv_cnt - rv_mark), 16'd0);
        check("arst_ready_after", 16'(ready), 16'd1);
        $display("reset during read addr=23");
        do_read("arst_mem12", 6'd12, 8'h00);
        do_read("arst_mem23", 6'd23, 8'h00);

        // Counter scenario from a fresh reset: 3 writes, 2 reads.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        do_write(6'd1, 8'h11);
        do_write(6'd2, 8'h22);
        do_write(6'd47, 8'h4F);
        do_read("cnt_rd1", 6'd1, 8'h11);
        do_read("cnt_rd47", 6'd47, 8'h4F);
`ifdef ACCESS_STATS_EN
        exp_wr = 16'd3; exp_rd = 16'd2;
`else
        exp_wr = 16'd0; exp_rd = 16'd0;
`endif
        check("stats_wr_count", wr_count, exp_wr);
        check("stats_rd_count", rd_count, exp_rd);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
